// File: rtl/fsk_pkg.sv
// Shared constants and state encoding for the FSK transmitter and its receiver.
package fsk_pkg;

    localparam int CNT_W = 8;

    localparam int PRE_LEN_DEF       = 160;
    localparam int POST_LEN_DEF      = 160;
    localparam int ZERO_LEN_DEF      = 48;
    localparam int ZERO_LONG_LEN_DEF = 56;
    localparam int ONE_LEN_DEF       = 50;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE1 = 3'd1,
        ST_PRE0 = 3'd2,
        ST_PRE2 = 3'd3,
        ST_DATA = 3'd4,
        ST_POST = 3'd5,
        ST_DONE = 3'd6
    } state_t;

endpackage

// File: rtl/fsk_tx_mchester_if.sv
// Bit-stream handshake between the frame builder and the FSK transmitter.
// Handshake: a bit is transferred on the rising sqwv edge where bit_ready and
// bit_valid are both high; bit_in and bit_last must be stable while bit_valid
// is high, and bit_ready never depends on bit_valid.
interface fsk_tx_mchester_if;
    logic bit_in;
    logic bit_valid;
    logic bit_last;
    logic bit_ready;

    modport master (output bit_in, output bit_valid, output bit_last, input bit_ready);
    modport slave  (input bit_in, input bit_valid, input bit_last, output bit_ready);
endinterface

// File: rtl/fsk_carrier_div.sv
// FSK carrier divider: half-period of 4 cycles for level 0, 5 for level 1.
// The phase restarts whenever the level changes so the first half-period
// after a change is always full length.
module fsk_carrier_div (
    input  logic sqwv,
    input  logic manual,
    input  logic en,
    input  logic level,
    output logic fsk_mod
);
    logic [2:0] phase_q;
    logic       prev_q;
    logic       mod_q;
    logic [2:0] half_end;

    // Last phase value of the current half-period.
    always_comb begin
        half_end = level ? 3'd4 : 3'd3;
    end

    // Phase counter, level tracker and carrier flop; carrier parked low when disabled.
    always_ff @(posedge sqwv) begin
        if (manual) begin
            phase_q <= '0;
            prev_q  <= 1'b0;
            mod_q   <= 1'b0;
        end else if (!en) begin
            phase_q <= '0;
            prev_q  <= level;
            mod_q   <= 1'b0;
        end else if (level != prev_q) begin
            prev_q  <= level;
            phase_q <= 3'd1;
        end else if (phase_q == half_end) begin
            phase_q <= '0;
            mod_q   <= ~mod_q;
        end else begin
            phase_q <= phase_q + 3'd1;
        end
    end

    assign fsk_mod = mod_q;
endmodule

// File: rtl/fsk_tx_mchester.sv
// Framed FSK transmitter: preamble 1/0/1, one level slot per bit, postamble 0.
// Zero slots follow a 48/56/48/48 rhythm indexed by zidx; one slots are fixed.
module fsk_tx_mchester
    import fsk_pkg::*;
#(
    parameter int PRE_LEN       = PRE_LEN_DEF,
    parameter int POST_LEN      = POST_LEN_DEF,
    parameter int ZERO_LEN      = ZERO_LEN_DEF,
    parameter int ZERO_LONG_LEN = ZERO_LONG_LEN_DEF,
    parameter int ONE_LEN       = ONE_LEN_DEF
) (
    input  logic               sqwv,
    input  logic               manual,
    input  logic               start,
    fsk_tx_mchester_if.slave   bus,
    output logic               fsk_level,
    output logic               fsk_mod,
    output logic               busy,
    output logic               done,
    output logic               underrun,
    output state_t             state_dbg
);
    localparam logic [CNT_W-1:0] PRE_END   = CNT_W'(PRE_LEN - 1);
    localparam logic [CNT_W-1:0] POST_END  = CNT_W'(POST_LEN - 1);
    localparam logic [CNT_W-1:0] ZERO_END  = CNT_W'(ZERO_LEN - 1);
    localparam logic [CNT_W-1:0] ZLONG_END = CNT_W'(ZERO_LONG_LEN - 1);
    localparam logic [CNT_W-1:0] ONE_END   = CNT_W'(ONE_LEN - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] slot_end_q, slot_end_d;
    logic [1:0]       zidx_q, zidx_d;
    logic             bit_q, bit_d;
    logic             last_q, last_d;
    logic             done_q, done_d;
    logic             underrun_q, underrun_d;
    logic             ready;

    // State and datapath registers.
    always_ff @(posedge sqwv) begin
        if (manual) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            slot_end_q <= '0;
            zidx_q     <= '0;
            bit_q      <= 1'b0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            slot_end_q <= slot_end_d;
            zidx_q     <= zidx_d;
            bit_q      <= bit_d;
            last_q     <= last_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
        end
    end

    // Next-state, slot counter and handshake decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        slot_end_d = slot_end_q;
        zidx_d     = zidx_q;
        bit_d      = bit_q;
        last_d     = last_q;
        done_d     = done_q;
        underrun_d = underrun_q;
        ready      = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                cnt_d = '0;
                if (start) begin
                    state_d    = ST_PRE1;
                    done_d     = 1'b0;
                    underrun_d = 1'b0;
                    zidx_d     = '0;
                end
            end
            ST_PRE1: if (cnt_q == PRE_END) begin state_d = ST_PRE0; cnt_d = '0; end
            ST_PRE0: if (cnt_q == PRE_END) begin state_d = ST_PRE2; cnt_d = '0; end
            ST_PRE2: if (cnt_q == PRE_END) ready = 1'b1;
            ST_DATA: begin
                if (cnt_q == slot_end_q) begin
                    cnt_d = '0;
                    if (last_q) state_d = ST_POST;
                    else        ready   = 1'b1;
                end
            end
            ST_POST: begin
                if (cnt_q == POST_END) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        // A slot boundary that wants a bit: take it, or close the frame short.
        if (ready) begin
            cnt_d = '0;
            if (bus.bit_valid) begin
                state_d = ST_DATA;
                bit_d   = bus.bit_in;
                last_d  = bus.bit_last;
                if (bus.bit_in) begin
                    slot_end_d = ONE_END;
                end else begin
                    slot_end_d = (zidx_q == 2'd1) ? ZLONG_END : ZERO_END;
                    zidx_d     = zidx_q + 2'd1;
                end
            end else begin
                state_d    = ST_POST;
                underrun_d = 1'b1;
            end
        end
    end

    // Output decode.
    always_comb begin
        fsk_level = (state_q == ST_PRE1) || (state_q == ST_PRE2) ||
                    ((state_q == ST_DATA) && bit_q);
        busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
    end

    assign bus.bit_ready = ready;
    assign done          = done_q;
    assign underrun      = underrun_q;
    assign state_dbg     = state_q;

    fsk_carrier_div u_carrier (
        .sqwv    (sqwv),
        .manual  (manual),
        .en      (busy),
        .level   (fsk_level),
        .fsk_mod (fsk_mod)
    );
endmodule
